// File: rtl/rvc_align_expand.sv
// Fetch-side halfword realigner with RV32C expansion toward decode.
// Optional instruction counters are enabled with `define INS_CNT_EN.
module rvc_align_expand #(
    parameter int unsigned BUF_HW   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_data_i,
    output logic        ins_valid_o,
    input  logic        ins_ready_i,
    output logic [31:0] ins_o,
    output logic [31:0] ins_pc_o,
    output logic        ins_compressed_o,
    output logic        ins_illegal_o
`ifdef INS_CNT_EN
    ,
    output logic [31:0] cnt_total_o,
    output logic [31:0] cnt_comp_o
`endif
);

    localparam int PW = $clog2(BUF_HW);
    localparam int CW = PW + 1;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic {S_RUN, S_SKIP} state_e;

    logic [15:0]   hw_buf_q [BUF_HW];
    logic [15:0]   hw_buf_d [BUF_HW];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d, push_n, pop_n;
    logic [31:0]   pc_q, pc_d;
    state_e        state_q, state_d;

    logic [15:0] c, next_hw;
    logic        head_comp, do_push, do_pop;
    logic [31:0] exp_ins;
    logic        exp_ill;
    logic [4:0]  rd, rs2, rd_p, rs1_p;

    assign c         = hw_buf_q[rd_ptr_q];
    assign next_hw   = hw_buf_q[rd_ptr_q + PW'(1)];
    assign head_comp = (c[1:0] != 2'b11);
    assign rd        = c[11:7];
    assign rs2       = c[6:2];
    assign rd_p      = {2'b01, c[4:2]};
    assign rs1_p     = {2'b01, c[9:7]};

    assign fetch_ready_o    = (count_q <= CW'(BUF_HW - 2));
    assign ins_valid_o      = !flush_i && (head_comp ? (count_q >= CW'(1)) : (count_q >= CW'(2)));
    assign ins_o            = ins_valid_o ? (head_comp ? exp_ins : {next_hw, c}) : 32'h0;
    assign ins_pc_o         = ins_valid_o ? pc_q : 32'h0;
    assign ins_compressed_o = ins_valid_o && head_comp;
    assign ins_illegal_o    = ins_valid_o && head_comp && exp_ill;
    assign do_push          = fetch_valid_i && fetch_ready_o;
    assign do_pop           = ins_valid_o && ins_ready_i;

    // RV32C to RV32I expansion of the head halfword
    always_comb begin
        exp_ins = 32'h0;
        exp_ill = 1'b0;
        case (c[1:0])
            2'b00: begin
                case (c[15:13])
                    3'b000: begin
                        exp_ins = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rd_p, OPC_OP_IMM};
                        exp_ill = (c[12:5] == 8'h00);
                    end
                    3'b010: exp_ins = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1_p, 3'b010, rd_p, OPC_LOAD};
                    3'b110: exp_ins = {5'b0, c[5], c[12], rd_p, rs1_p, 3'b010, c[11:10], c[6], 2'b00, OPC_STORE};
                    default: exp_ill = 1'b1;
                endcase
            end
            2'b01: begin
                case (c[15:13])
                    3'b000: exp_ins = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, OPC_OP_IMM};
                    3'b001, 3'b101:
                        exp_ins = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3],
                                   c[12], {8{c[12]}}, {4'b0000, ~c[15]}, OPC_JAL};
                    3'b010: exp_ins = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, OPC_OP_IMM};
                    3'b011: begin
                        exp_ill = ({c[12], c[6:2]} == 6'h00);
                        if (rd == 5'd2)
                            exp_ins = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000,
                                       5'd2, 3'b000, 5'd2, OPC_OP_IMM};
                        else
                            exp_ins = {{15{c[12]}}, c[6:2], rd, OPC_LUI};
                    end
                    3'b100: begin
                        case (c[11:10])
                            2'b00: begin
                                exp_ins = {7'b0000000, c[6:2], rs1_p, 3'b101, rs1_p, OPC_OP_IMM};
                                exp_ill = c[12];
                            end
                            2'b01: begin
                                exp_ins = {7'b0100000, c[6:2], rs1_p, 3'b101, rs1_p, OPC_OP_IMM};
                                exp_ill = c[12];
                            end
                            2'b10: exp_ins = {{7{c[12]}}, c[6:2], rs1_p, 3'b111, rs1_p, OPC_OP_IMM};
                            default: begin
                                exp_ill = c[12];
                                case (c[6:5])
                                    2'b00:   exp_ins = {7'b0100000, rd_p, rs1_p, 3'b000, rs1_p, OPC_OP};
                                    2'b01:   exp_ins = {7'b0000000, rd_p, rs1_p, 3'b100, rs1_p, OPC_OP};
                                    2'b10:   exp_ins = {7'b0000000, rd_p, rs1_p, 3'b110, rs1_p, OPC_OP};
                                    default: exp_ins = {7'b0000000, rd_p, rs1_p, 3'b111, rs1_p, OPC_OP};
                                endcase
                            end
                        endcase
                    end
                    default:
                        exp_ins = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rs1_p, 2'b00, c[13],
                                   c[11:10], c[4:3], c[12], OPC_BRANCH};
                endcase
            end
            2'b10: begin
                case (c[15:13])
                    3'b000: begin
                        exp_ins = {7'b0000000, c[6:2], rd, 3'b001, rd, OPC_OP_IMM};
                        exp_ill = c[12];
                    end
                    3'b010: begin
                        exp_ins = {4'b0000, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, OPC_LOAD};
                        exp_ill = (rd == 5'd0);
                    end
                    3'b100: begin
                        if (!c[12]) begin
                            if (rs2 == 5'd0) begin
                                exp_ins = {12'h000, rd, 3'b000, 5'd0, OPC_JALR};
                                exp_ill = (rd == 5'd0);
                            end else begin
                                exp_ins = {7'b0000000, rs2, 5'd0, 3'b000, rd, OPC_OP};
                            end
                        end else if (rs2 == 5'd0) begin
                            if (rd == 5'd0)
                                exp_ins = 32'h0010_0073;
                            else
                                exp_ins = {12'h000, rd, 3'b000, 5'd1, OPC_JALR};
                        end else begin
                            exp_ins = {7'b0000000, rs2, rd, 3'b000, rd, OPC_OP};
                        end
                    end
                    3'b110: exp_ins = {4'b0000, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, OPC_STORE};
                    default: exp_ill = 1'b1;
                endcase
            end
            default: begin
                exp_ins = 32'h0;
                exp_ill = 1'b0;
            end
        endcase
        if (exp_ill)
            exp_ins = {16'h0000, c};
    end

    // Buffer bookkeeping; flush wins over push and pop, and a skip-aligned push keeps only its upper halfword
    always_comb begin
        hw_buf_d = hw_buf_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        pc_d     = pc_q;
        state_d  = state_q;
        push_n   = '0;
        pop_n    = '0;
        count_d  = count_q;
        if (flush_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            pc_d     = flush_pc_i & 32'hFFFF_FFFE;
            state_d  = flush_pc_i[1] ? S_SKIP : S_RUN;
        end else begin
            if (do_push) begin
                if (state_q == S_SKIP) begin
                    hw_buf_d[wr_ptr_q] = fetch_data_i[31:16];
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    push_n   = CW'(1);
                    state_d  = S_RUN;
                end else begin
                    hw_buf_d[wr_ptr_q]          = fetch_data_i[15:0];
                    hw_buf_d[wr_ptr_q + PW'(1)] = fetch_data_i[31:16];
                    wr_ptr_d = wr_ptr_q + PW'(2);
                    push_n   = CW'(2);
                end
            end
            if (do_pop) begin
                pop_n    = head_comp ? CW'(1) : CW'(2);
                rd_ptr_d = rd_ptr_q + (head_comp ? PW'(1) : PW'(2));
                pc_d     = pc_q + (head_comp ? 32'd2 : 32'd4);
            end
            count_d = count_q + push_n - pop_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hw_buf_q <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= RESET_PC;
            state_q  <= S_RUN;
        end else begin
            hw_buf_q <= hw_buf_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
            state_q  <= state_d;
        end
    end

`ifdef INS_CNT_EN
    logic [31:0] cnt_total_q, cnt_total_d, cnt_comp_q, cnt_comp_d;

    always_comb begin
        cnt_total_d = cnt_total_q;
        cnt_comp_d  = cnt_comp_q;
        if (do_pop) begin
            cnt_total_d = cnt_total_q + 32'd1;
            if (head_comp)
                cnt_comp_d = cnt_comp_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_total_q <= '0;
            cnt_comp_q  <= '0;
        end else begin
            cnt_total_q <= cnt_total_d;
            cnt_comp_q  <= cnt_comp_d;
        end
    end

    assign cnt_total_o = cnt_total_q;
    assign cnt_comp_o  = cnt_comp_q;
`endif

endmodule

// File: tb/tb_rvc_align_expand.sv
// Directed bench for rvc_align_expand: expansion table plus alignment, backpressure and flush sequences.
module tb_rvc_align_expand;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = 32'h0;
    logic        fetch_valid_i = 1'b0;
    logic        fetch_ready_o;
    logic [31:0] fetch_data_i = 32'h0;
    logic        ins_valid_o;
    logic        ins_ready_i = 1'b0;
    logic [31:0] ins_o;
    logic [31:0] ins_pc_o;
    logic        ins_compressed_o;
    logic        ins_illegal_o;
`ifdef INS_CNT_EN
    logic [31:0] cnt_total_o, cnt_comp_o;
    logic [31:0] base_total, base_comp;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic [15:0] hw;
        logic [31:0] ins;
        logic        ill;
    } vec_t;

    vec_t vecs [29];

    rvc_align_expand #(.BUF_HW(4), .RESET_PC(32'h0)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush_i          (flush_i),
        .flush_pc_i       (flush_pc_i),
        .fetch_valid_i    (fetch_valid_i),
        .fetch_ready_o    (fetch_ready_o),
        .fetch_data_i     (fetch_data_i),
        .ins_valid_o      (ins_valid_o),
        .ins_ready_i      (ins_ready_i),
        .ins_o            (ins_o),
        .ins_pc_o         (ins_pc_o),
        .ins_compressed_o (ins_compressed_o),
        .ins_illegal_o    (ins_illegal_o)
`ifdef INS_CNT_EN
        ,
        .cnt_total_o      (cnt_total_o),
        .cnt_comp_o       (cnt_comp_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // When no instruction is expected only the valid flag is compared
    task automatic checkOutput(input string name, input logic exp_valid, input logic [31:0] exp_ins,
                               input logic [31:0] exp_pc, input logic exp_comp, input logic exp_ill);
        logic [66:0] act, exp;
        act = {ins_valid_o, ins_compressed_o, ins_illegal_o, ins_o, ins_pc_o};
        exp = {exp_valid, exp_comp, exp_ill, exp_ins, exp_pc};
        if (!exp_valid) begin
            act = {ins_valid_o, 66'h0};
            exp = 67'h0;
        end
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got v=%b c=%b i=%b ins=%h pc=%h expected v=%b c=%b i=%b ins=%h pc=%h",
                     name, ins_valid_o, ins_compressed_o, ins_illegal_o, ins_o, ins_pc_o,
                     exp_valid, exp_comp, exp_ill, exp_ins, exp_pc);
        end
    endtask

    task automatic applyStimulus(input logic flush, input logic [31:0] fpc, input logic push,
                                 input logic [31:0] data, input logic ready);
        flush_i       = flush;
        flush_pc_i    = fpc;
        fetch_valid_i = push;
        fetch_data_i  = data;
        ins_ready_i   = ready;
        @(posedge clk);
        #1;
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{16'h0808, 32'h0101_0513, 1'b0};
        vecs[1]  = '{16'h0008, 32'h0000_0008, 1'b1};
        vecs[2]  = '{16'h41C8, 32'h0045_A503, 1'b0};
        vecs[3]  = '{16'hC588, 32'h00A5_A423, 1'b0};
        vecs[4]  = '{16'h557D, 32'hFFF0_0513, 1'b0};
        vecs[5]  = '{16'h6505, 32'h0000_1537, 1'b0};
        vecs[6]  = '{16'h6501, 32'h0000_6501, 1'b1};
        vecs[7]  = '{16'h6141, 32'h0101_0113, 1'b0};
        vecs[8]  = '{16'h8505, 32'h4015_5513, 1'b0};
        vecs[9]  = '{16'h9105, 32'h0000_9105, 1'b1};
        vecs[10] = '{16'h8D0D, 32'h40B5_0533, 1'b0};
        vecs[11] = '{16'h8D6D, 32'h00B5_7533, 1'b0};
        vecs[12] = '{16'hA001, 32'h0000_006F, 1'b0};
        vecs[13] = '{16'hBFFD, 32'hFFFF_F06F, 1'b0};
        vecs[14] = '{16'h2009, 32'h0020_00EF, 1'b0};
        vecs[15] = '{16'hC101, 32'h0005_0063, 1'b0};
        vecs[16] = '{16'hFD7D, 32'hFE05_1FE3, 1'b0};
        vecs[17] = '{16'h050E, 32'h0035_1513, 1'b0};
        vecs[18] = '{16'h4512, 32'h0041_2503, 1'b0};
        vecs[19] = '{16'h4012, 32'h0000_4012, 1'b1};
        vecs[20] = '{16'h8082, 32'h0000_8067, 1'b0};
        vecs[21] = '{16'h8002, 32'h0000_8002, 1'b1};
        vecs[22] = '{16'h852E, 32'h00B0_0533, 1'b0};
        vecs[23] = '{16'h9002, 32'h0010_0073, 1'b0};
        vecs[24] = '{16'h9502, 32'h0005_00E7, 1'b0};
        vecs[25] = '{16'h952E, 32'h00B5_0533, 1'b0};
        vecs[26] = '{16'hC22A, 32'h00A1_2223, 1'b0};
        vecs[27] = '{16'h8000, 32'h0000_8000, 1'b1};
        vecs[28] = '{16'h0505, 32'h0015_0513, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkVal("reset_ins_o", ins_o, 32'h0);
        checkVal("reset_pc_o", ins_pc_o, 32'h0);
        checkVal("reset_fetch_ready", {31'h0, fetch_ready_o}, 32'h1);
        rst_n = 1'b1;

        // 32-bit passthrough, one cycle after push
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h00A5_0513, 1'b0);
        checkOutput("pass32", 1'b1, 32'h00A5_0513, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("pass32_popped", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Two compressed halfwords in one word
        applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h4505_0505, 1'b1);
        checkOutput("pair_first", 1'b1, 32'h0015_0513, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("pair_second", 1'b1, 32'h0010_0513, 32'h2, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("pair_empty", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // 32-bit instruction straddling two fetch words, with simultaneous push and pop
        applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0513_0505, 1'b1);
        checkOutput("straddle_c", 1'b1, 32'h0015_0513, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h4505_00A5, 1'b1);
        checkOutput("straddle_32", 1'b1, 32'h00A5_0513, 32'h2, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("straddle_tail", 1'b1, 32'h0010_0513, 32'h6, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("straddle_empty", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Backpressure: fill the buffer, hold, then release
        applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h00A5_0513, 1'b0);
        checkVal("bp_ready_half", {31'h0, fetch_ready_o}, 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h00B5_0513, 1'b0);
        checkVal("bp_ready_full", {31'h0, fetch_ready_o}, 32'h0);
        checkOutput("bp_head", 1'b1, 32'h00A5_0513, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        checkOutput("bp_hold", 1'b1, 32'h00A5_0513, 32'h0, 1'b0, 1'b0);
        ins_ready_i = 1'b1;
        #1;
        checkVal("bp_ready_registered", {31'h0, fetch_ready_o}, 32'h0);
        @(posedge clk);
        #1;
        checkVal("bp_ready_after_pop", {31'h0, fetch_ready_o}, 32'h1);
        checkOutput("bp_second", 1'b1, 32'h00B5_0513, 32'h4, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("bp_drop_full_push", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Flush mid-stream to a halfword-aligned target; push in the flush cycle is dropped
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h00A5_0513, 1'b0);
        flush_i       = 1'b1;
        flush_pc_i    = 32'h0000_0103;
        fetch_valid_i = 1'b1;
        fetch_data_i  = 32'h4505_4505;
        #1;
        checkVal("fl_valid_during", {31'h0, ins_valid_o}, 32'h0);
        @(posedge clk);
        #1;
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        checkOutput("fl_empty", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h4505_FFFF, 1'b0);
        checkOutput("fl_skip_low", 1'b1, 32'h0010_0513, 32'h102, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("fl_skip_popped", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h00A5_0513, 1'b0);
        checkOutput("fl_run_after_skip", 1'b1, 32'h00A5_0513, 32'h104, 1'b0, 1'b0);

        // Second flush while skipping re-evaluates alignment
        applyStimulus(1'b1, 32'h106, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0001_4505, 1'b0);
        checkOutput("fl_reeval", 1'b1, 32'h0010_0513, 32'h200, 1'b1, 1'b0);

        // All-zero halfwords are illegal, still handshaken one halfword at a time
        applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
`ifdef INS_CNT_EN
        base_total = cnt_total_o;
        base_comp  = cnt_comp_o;
`endif
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0000, 1'b0);
        checkOutput("ill_zero_first", 1'b1, 32'h0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("ill_zero_second", 1'b1, 32'h0, 32'h2, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("ill_zero_empty", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef INS_CNT_EN
        checkVal("cnt_total_delta", cnt_total_o - base_total, 32'd2);
        checkVal("cnt_comp_delta", cnt_comp_o - base_comp, 32'd2);
`endif

        // Expansion table: each halfword is placed at the head of a freshly flushed buffer
        for (int i = 0; i < 29; i++) begin
            applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
            applyStimulus(1'b0, 32'h0, 1'b1, {16'h0001, vecs[i].hw}, 1'b0);
            checkOutput($sformatf("exp_%0d_%h", i, vecs[i].hw), 1'b1, vecs[i].ins, 32'h0, 1'b1, vecs[i].ill);
        end

        // Asynchronous reset in the middle of a cycle
        applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h00A5_0513, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkVal("async_reset_ready", {31'h0, fetch_ready_o}, 32'h1);
        #2;
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rvc_align_expand.md
Name: rvc_align_expand

Overview:
- Fetch-side realigner and RV32C expander between the instruction-fetch word stream and the decode stage.
- Accepts 32-bit fetch words into a halfword buffer and tracks the PC of the buffer head.
- Extracts one instruction per handshake: 16-bit compressed, or 32-bit, including 32-bit instructions that straddle two fetch words.
- Compressed halfwords are expanded to their RV32I equivalent; illegal and reserved encodings are flagged.

Parameters:
- BUF_HW, 4, halfword buffer depth; power of 2, >= 4.
- RESET_PC, 32'h0000_0000, head PC after reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  discard buffer and redirect.
- flush_pc_i  in  32  new head PC; bit 0 ignored.
- fetch_valid_i  in  1  fetch word valid.
- fetch_ready_o  out  1  buffer can accept a word.
- fetch_data_i  in  32  fetch word; low halfword is at the lower address.
- ins_valid_o  out  1  instruction available.
- ins_ready_i  in  1  decode accepts.
- ins_o  out  32  expanded or passthrough instruction.
- ins_pc_o  out  32  PC of ins_o.
- ins_compressed_o  out  1  source was 16-bit.
- ins_illegal_o  out  1  illegal or reserved encoding.

Behaviour:
- Reset values: buffer empty, count=0, state S_RUN, pc_q=RESET_PC, ins_valid_o=0, fetch_ready_o=1, ins_o/ins_pc_o=0, ins_compressed_o=0, ins_illegal_o=0.
- Buffer: circular, BUF_HW halfwords; rd/wr pointers wrap modulo BUF_HW.
- Push: on fetch_valid_i && fetch_ready_o. Writes 2 halfwords; in S_SKIP writes only the high halfword, then state goes to S_RUN.
- fetch_ready_o = (BUF_HW - count >= 2). Registered-state based, not dependent on same-cycle pop.
- Head classification: compressed when head[1:0] != 2'b11.
- ins_valid_o = !flush_i && ((compressed && count>=1) || (!compressed && count>=2)).
- Outputs are combinational from registered buffer state. Latency from push to ins_valid_o is 1 cycle.
- Pop: on ins_valid_o && ins_ready_i. Removes 1 halfword (compressed) or 2 (32-bit); pc_q += 2 or 4.
- 32-bit instruction: ins_o = {head+1, head}, passed through unchanged; ins_illegal_o=0.
- Compressed expansion:
  - Quadrant 0: C.ADDI4SPN, C.LW, C.SW.
  - Quadrant 1: C.ADDI, C.JAL, C.LI, C.LUI, C.ADDI16SP, C.SRLI, C.SRAI, C.ANDI, C.SUB, C.XOR, C.OR, C.AND, C.J, C.BEQZ, C.BNEZ.
  - Quadrant 2: C.SLLI, C.LWSP, C.JR, C.MV, C.EBREAK, C.JALR, C.ADD, C.SWSP.
  - All immediates are sign- or zero-extended per RVC spec.
  - C.SRAI sets funct7 = 7'b0100000.
  - C.MV expands to add rd, x0, rs2.
  - Branch immediate bit 12 is ins[12].
- Illegal: halfword 0x0000; ADDI4SPN with nzuimm=0; LWSP with rd=0; JR with rs1=0; LUI/ADDI16SP with imm=0; shift with shamt[5]=1; all unlisted funct3 or funct6 encodings.
  - On illegal: ins_illegal_o=1, ins_compressed_o=1, ins_o = {16'h0, halfword}. It is still handshaken and pops 1 halfword.
- Simultaneous push and pop in one cycle: count += pushed - popped.
- Flush has priority over push and pop:
  - Next cycle: count=0, pc_q = {flush_pc_i[31:1], 1'b0}.
  - State becomes S_SKIP if flush_pc_i[1]=1, else S_RUN.
  - Any push in the flush cycle is dropped.
- State machine:
  - S_RUN -> S_SKIP on flush with pc[1]=1.
  - S_SKIP -> S_RUN on the first push.
  - A flush while in S_SKIP re-evaluates pc[1].
- Reset mid-operation: asynchronous return to reset values; buffer contents are don't-care.

Optional Feature:
- Macro INS_CNT_EN.
- When defined: adds ports cnt_total_o[31:0] and cnt_comp_o[31:0], both reset to 0.
  - Increment on each pop; cnt_comp_o increments only for compressed pops.
  - Wrap at 2^32.
  - Neither counter is cleared by flush.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, push 32'h00A50513 -> next cycle ins_valid_o=1, ins_o=32'h00A50513, ins_pc_o=0, compressed=0.
- Push 32'h45050505 with ins_ready_i=1 -> ins_o 32'h00150513 @pc 0, then 32'h00100513 @pc 2, both compressed=1.
- Straddle: push 32'h05130505 then 32'h450500A5 -> outputs 32'h00150513@0, 32'h00A50513@2, 32'h00100513@6.
- Backpressure, BUF_HW=4, ins_ready_i=0:
  - After 2 pushes fetch_ready_o=0 and ins_o/ins_pc_o are held stable.
  - Raise ins_ready_i with a 32-bit head -> fetch_ready_o=1 the next cycle.
- Flush to 32'h102 mid-stream, then push 32'h4505FFFF -> the low halfword is dropped; ins_o=32'h00100513, ins_pc_o=32'h102.
- Push 32'h00000000 -> ins_illegal_o=1, compressed=1, ins_o=0, pc advances by 2 per pop.
  - With INS_CNT_EN: cnt_comp_o=2, cnt_total_o=2.
